clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//   Runtime-programmable clock divider for the Nexys A7 100 MHz system clock,
//   generalising the fixed 100 MHz -> 4 MHz generator to any integer divisor N.
//   Output high ceil(N/2) cycles, then low floor(N/2) cycles.
//   Adds enable/stop control, a one-cycle rising-edge tick, and a divisor-load
//   handshake that only takes effect at period boundaries, so the output never glitches.
//   Feeds serial peripheral clocks such as the accelerometer SPI and other timing users.
// PARAMETERS
//   CNT_W        16   divisor/counter width; legal N = 2 .. 2^CNT_W-1
//   DEFAULT_DIV  25   divisor in force after reset (25 -> 4 MHz, 13 high / 12 low)
// PORTS
//   CLK100MHZ   in   1      system clock, all logic on rising edge
//   reset       in   1      asynchronous, active-high reset
//   enable      in   1      1 = run divider; 0 = stop at the end of the current period
//   div_in      in   CNT_W  requested divisor N
//   div_load    in   1      request to load div_in (sampled every cycle)
//   div_ack     out  1      1-cycle pulse: div_in accepted into pending register
//   div_err     out  1      1-cycle pulse: div_in < 2 rejected, nothing changed
//   active_div  out  CNT_W  divisor currently governing clk_out
//   clk_out     out  1      divided clock (registered)
//   tick        out  1      1-cycle pulse coincident with each clk_out rising edge
//   running     out  1      1 while in HIGH or LOW state
// BEHAVIOUR
//   Reset (async): state=STOPPED, clk_out=0, tick=0, div_ack=0, div_err=0,
//     running=0, active_div=DEFAULT_DIV, pending flag cleared, counter=0.
//   FSM states: STOPPED, HIGH, LOW. All outputs are registered.
//   H = (N+1)>>1 and L = N>>1. Compute both in CNT_W+1 bits; no overflow at N=2^CNT_W-1.
//   STOPPED: when enable=1 at an edge, apply pending divisor if one is held.
//     Next state is HIGH, with clk_out<=1, tick<=1, counter<=0.
//   HIGH: counter counts 0..H-1. At H-1 the next state is LOW, with clk_out<=0 and counter<=0.
//   LOW: counter counts 0..L-1. At L-1 the next action depends on enable:
//     enable=1: apply pending divisor if held, then enter HIGH (clk_out<=1, tick<=1, counter<=0).
//     enable=0: enter STOPPED with clk_out held 0.
//   Period is exactly N cycles. A new divisor is applied on the same edge that starts the next
//     HIGH phase, and the H of that period is derived from the new N.
//   Dropping enable mid-period never truncates the period: the current HIGH/LOW phases complete.
//   Load handshake: div_load=1 with div_in>=2 captures div_in into the pending register and sets
//     the pending flag; div_ack=1 on the following cycle.
//   A second load before application overwrites the pending value and is acked again.
//   div_load=1 with div_in<2: div_err=1 on the following cycle. Pending value, pending flag
//     and active_div are unchanged.
//   If a load and a period boundary occur on the same edge, the old pending value (if any) is
//     applied. The new value becomes pending for the next boundary.
//   A load in STOPPED is applied on the edge that starts HIGH.
//   Reset asserted mid-period: clk_out=0 immediately, and active_div returns to DEFAULT_DIV.
//   running = (state != STOPPED). tick is never asserted in STOPPED.
// TESTING
//   Reset, then enable=1 with default N=25: clk_out high 13 cycles, low 12; tick every 25 cycles.
//   While running at 25, load 4 mid-HIGH: div_ack one cycle later, current period still 13/12.
//     Following periods are 2/2, and active_div changes at the next tick.
//   Load N=2 -> clk_out 1/1 toggling. Load N=3 -> 2 high / 1 low. Load 65535 -> 32768 / 32767.
//   Load 0 and 1 -> div_err pulse each, no div_ack, active_div and period unchanged.
//   Drop enable on 5th HIGH cycle at N=25: HIGH completes, 12 LOW cycles follow, then STOPPED.
//     After that clk_out=0, running=0, no tick. Re-enable -> clk_out rises on the next edge.
//   Assert reset mid-HIGH at N=4: clk_out=0 asynchronously, active_div=25, state=STOPPED.
//   Load on the exact LOW->HIGH boundary edge: the new value is applied one period later.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: clk_out is high ceil(N/2) and low floor(N/2)
// cycles; new divisors are staged and only take effect at the start of a HIGH phase.
module clk_div_prog #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 25
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic [CNT_W-1:0] active_div,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    typedef enum logic [1:0] {
        StStopped,
        StHigh,
        StLow
    } state_e;

    localparam logic [CNT_W-1:0] DefaultDiv = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MinDiv     = CNT_W'(2);
    localparam logic [CNT_W:0]   One        = (CNT_W+1)'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             running_q, running_d;

    logic [CNT_W:0]   half_hi;
    logic [CNT_W:0]   half_lo;
    logic             hi_last;
    logic             lo_last;
    logic             load_ok;
    logic             start_period;

    // Phase lengths in CNT_W+1 bits so N = 2^CNT_W-1 does not wrap when rounding up.
    always_comb begin
        half_hi = ({1'b0, active_q} + One) >> 1;
        half_lo = {1'b0, active_q} >> 1;
        hi_last = ({1'b0, cnt_q} == (half_hi - One));
        lo_last = ({1'b0, cnt_q} == (half_lo - One));
        load_ok = div_load && (div_in >= MinDiv);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        clk_d        = clk_q;
        tick_d       = 1'b0;
        ack_d        = load_ok;
        err_d        = div_load && !load_ok;
        start_period = 1'b0;

        case (state_q)
            StStopped: begin
                if (enable) begin
                    start_period = 1'b1;
                end
            end
            StHigh: begin
                if (hi_last) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLow: begin
                if (lo_last) begin
                    if (enable) begin
                        start_period = 1'b1;
                    end else begin
                        state_d = StStopped;
                        cnt_d   = '0;
                        clk_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StStopped;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        if (start_period) begin
            state_d = StHigh;
            cnt_d   = '0;
            clk_d   = 1'b1;
            tick_d  = 1'b1;
            if (pend_vld_q) begin
                active_d   = pend_q;
                pend_vld_d = 1'b0;
            end
        end

        // A load on a boundary edge is staged after the old pending value has been consumed.
        if (load_ok) begin
            pend_d     = div_in;
            pend_vld_d = 1'b1;
        end

        running_d = (state_d != StStopped);
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q    <= StStopped;
            cnt_q      <= '0;
            active_q   <= DefaultDiv;
            pend_q     <= DefaultDiv;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            running_q  <= running_d;
        end
    end

    assign div_ack    = ack_q;
    assign div_err    = err_q;
    assign active_div = active_q;
    assign clk_out    = clk_q;
    assign tick       = tick_q;
    assign running    = running_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: table of divisors with expected high/low phase lengths,
// plus hand-written sequences for staging, rejection, stop, reset and boundary loads.
module tb_clk_div_prog;

    localparam int CNT_W = 16;
    localparam int LIMIT = 70000;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             div_ack;
    logic             div_err;
    logic [CNT_W-1:0] active_div;
    logic             clk_out;
    logic             tick;
    logic             running;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int div;
        int hi;
        int lo;
    } vec_t;

    vec_t vecs[5];

    clk_div_prog #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(25)
    ) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .enable    (enable),
        .div_in    (div_in),
        .div_load  (div_load),
        .div_ack   (div_ack),
        .div_err   (div_err),
        .active_div(active_div),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at the negedge of a tick cycle; returns at the negedge of the next tick cycle.
    task automatic measure(output int hi, output int lo, output int nt);
        hi = 0;
        lo = 0;
        nt = 0;
        while (clk_out === 1'b1 && hi < LIMIT) begin
            nt += int'(tick);
            hi++;
            step();
        end
        while (clk_out === 1'b0 && lo < LIMIT) begin
            nt += int'(tick);
            lo++;
            step();
        end
    endtask

    task automatic check_period(input string tag, input int ehi, input int elo);
        int hi, lo, nt;
        measure(hi, lo, nt);
        chk({tag, "_high"}, 32'(hi), 32'(ehi));
        chk({tag, "_low"}, 32'(lo), 32'(elo));
        chk({tag, "_ticks"}, 32'(nt), 32'd1);
        chk({tag, "_next_tick"}, 32'(tick), 32'd1);
    endtask

    initial begin
        int c;
        int hi, lo, nt;
        int bad;

        vecs[0] = '{div: 2,     hi: 1,     lo: 1};
        vecs[1] = '{div: 3,     hi: 2,     lo: 1};
        vecs[2] = '{div: 7,     hi: 4,     lo: 3};
        vecs[3] = '{div: 25,    hi: 13,    lo: 12};
        vecs[4] = '{div: 65535, hi: 32768, lo: 32767};

        reset    = 1'b1;
        enable   = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        step();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_active", 32'(active_div), 32'd25);
        chk("rst_ack", 32'(div_ack), 32'd0);
        chk("rst_err", 32'(div_err), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_clk_out", 32'(clk_out), 32'd0);

        // Default divisor.
        enable = 1'b1;
        step();
        chk("start_tick", 32'(tick), 32'd1);
        chk("start_running", 32'(running), 32'd1);
        check_period("n25", 13, 12);

        // Load 4 on the 4th HIGH cycle: current period unaffected.
        repeat (3) step();
        div_in   = 16'd4;
        div_load = 1'b1;
        step();
        chk("midhi_ack", 32'(div_ack), 32'd1);
        chk("midhi_active_old", 32'(active_div), 32'd25);
        div_load = 1'b0;
        c = 0;
        while (tick !== 1'b1 && c < 100) begin
            c++;
            step();
        end
        chk("midhi_wait", 32'(c), 32'd21);
        chk("midhi_active_new", 32'(active_div), 32'd4);
        check_period("n4", 2, 2);

        // Rejected divisors 0 and 1.
        div_in   = 16'd0;
        div_load = 1'b1;
        step();
        chk("err0_err", 32'(div_err), 32'd1);
        chk("err0_ack", 32'(div_ack), 32'd0);
        div_in = 16'd1;
        step();
        chk("err1_err", 32'(div_err), 32'd1);
        chk("err1_ack", 32'(div_ack), 32'd0);
        div_load = 1'b0;
        step();
        chk("err_clear", 32'(div_err), 32'd0);
        c = 0;
        while (tick !== 1'b1 && c < 100) begin
            c++;
            step();
        end
        chk("err_wait", 32'(c), 32'd1);
        chk("err_active", 32'(active_div), 32'd4);
        check_period("n4_after_err", 2, 2);

        // Asynchronous reset mid-HIGH at N=4.
        step();
        chk("prerst_clk_out", 32'(clk_out), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_clk_out", 32'(clk_out), 32'd0);
        chk("arst_active", 32'(active_div), 32'd25);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("postrst_clk_out", 32'(clk_out), 32'd1);
        chk("postrst_tick", 32'(tick), 32'd1);
        chk("postrst_active", 32'(active_div), 32'd25);

        // Drop enable on the 5th HIGH cycle at N=25.
        repeat (4) step();
        enable = 1'b0;
        hi = 0;
        lo = 0;
        while (clk_out === 1'b1 && hi < 100) begin
            hi++;
            step();
        end
        while (clk_out === 1'b0 && running === 1'b1 && lo < 100) begin
            lo++;
            step();
        end
        chk("stop_high_rest", 32'(hi), 32'd9);
        chk("stop_low", 32'(lo), 32'd12);
        chk("stop_running", 32'(running), 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (tick !== 1'b0 || clk_out !== 1'b0 || running !== 1'b0) bad++;
            step();
        end
        chk("stopped_quiet", 32'(bad), 32'd0);
        enable = 1'b1;
        step();
        chk("reen_clk_out", 32'(clk_out), 32'd1);
        chk("reen_tick", 32'(tick), 32'd1);

        // Load exactly on the LOW->HIGH boundary edge.
        repeat (24) step();
        chk("bnd_pre_clk_out", 32'(clk_out), 32'd0);
        div_in   = 16'd4;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("bnd_tick", 32'(tick), 32'd1);
        chk("bnd_ack", 32'(div_ack), 32'd1);
        chk("bnd_active_old", 32'(active_div), 32'd25);
        check_period("bnd_n25", 13, 12);
        chk("bnd_active_new", 32'(active_div), 32'd4);
        check_period("bnd_n4", 2, 2);

        // Table of divisors, each loaded at a tick and measured once applied.
        foreach (vecs[i]) begin
            div_in   = CNT_W'(vecs[i].div);
            div_load = 1'b1;
            step();
            div_load = 1'b0;
            chk($sformatf("v%0d_ack", vecs[i].div), 32'(div_ack), 32'd1);
            c = 0;
            while (!(tick === 1'b1 && int'(active_div) == vecs[i].div) && c < 100) begin
                c++;
                step();
            end
            chk($sformatf("v%0d_applied", vecs[i].div), 32'(active_div), 32'(vecs[i].div));
            check_period($sformatf("v%0d", vecs[i].div), vecs[i].hi, vecs[i].lo);
        end

        reset = 1'b1;
        #1;
        chk("final_rst_clk_out", 32'(clk_out), 32'd0);
        chk("final_rst_active", 32'(active_div), 32'd25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
